mips_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the bare PC register and PC+4/branch mux with the following:
- an imem request/ready handshake;
- a bimodal branch history table (BHT) and a branch target buffer (BTB);
- mispredict redirect and flush from the resolving stage;
- stall hold from the hazard unit;
- a clean halt on opcode HALT_OP instead of simulation termination.

It feeds the IF/ID register with pc, instr and the prediction, which travel down the pipe to the resolve stage.

---
 rtl/mips_fetch_unit_if.sv | 40 ++++
 rtl/mips_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_mips_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-stage bus bundle: imem handshake, IF/ID payload and resolve-stage feedback.
// The master side is the fetch unit; the slave side is imem plus the downstream pipe.
interface mips_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       fetch_instr;
  logic              fetch_pred_taken;
  logic [ADDR_W-1:0] fetch_pred_target;

  logic              res_valid;
  logic              res_is_branch;
  logic [ADDR_W-1:0] res_pc;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic              res_pred_taken;
  logic [ADDR_W-1:0] res_pred_target;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rdata,
    output fetch_valid, fetch_pc, fetch_instr, fetch_pred_taken, fetch_pred_target,
    input  res_valid, res_is_branch, res_pc, res_taken, res_target,
    input  res_pred_taken, res_pred_target
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rdata,
    input  fetch_valid, fetch_pc, fetch_instr, fetch_pred_taken, fetch_pred_target,
    output res_valid, res_is_branch, res_pc, res_taken, res_target,
    output res_pred_taken, res_pred_target
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem handshake, bimodal BHT + BTB prediction,
// mispredict redirect/flush, stall hold and halt on HALT_OP.
module mips_fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h1000),
  parameter int unsigned       IDX_W     = 4,
  parameter int unsigned       PRED_MODE = 1,
  parameter logic [5:0]        HALT_OP   = 6'h3f,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  mips_fetch_unit_if.master bus,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] mispredictCnt
);
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;

  typedef enum logic {S_FETCH, S_HALTED} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pc, pcNext;
  logic              fetchValid, fetchValidNext;
  logic [ADDR_W-1:0] fetchPc, fetchPcNext;
  logic [31:0]       fetchInstr, fetchInstrNext;
  logic              fetchPredTaken, fetchPredTakenNext;
  logic [ADDR_W-1:0] fetchPredTarget, fetchPredTargetNext;
  logic [CNT_W-1:0]  cntNext;

  logic [1:0]        bht       [ENTRIES];
  logic              btbValid  [ENTRIES];
  logic [TAG_W-1:0]  btbTag    [ENTRIES];
  logic [ADDR_W-1:0] btbTarget [ENTRIES];

  logic [IDX_W-1:0]  idx, resIdx;
  logic [TAG_W-1:0]  tag, resTag;
  logic              predTaken, mispredict;
  logic [ADDR_W-1:0] nextPc, correctPc;

  // Prediction on the current pc
  assign idx       = pc[IDX_W+1:2];
  assign tag       = pc[ADDR_W-1:IDX_W+2];
  assign predTaken = (PRED_MODE != 0) && bht[idx][1] && btbValid[idx] && (btbTag[idx] == tag);
  assign nextPc    = predTaken ? btbTarget[idx] : pc + ADDR_W'(4);

  // Resolve-stage check; a non-branch can carry a taken prediction through BTB aliasing
  assign resIdx     = bus.res_pc[IDX_W+1:2];
  assign resTag     = bus.res_pc[ADDR_W-1:IDX_W+2];
  assign mispredict = bus.res_is_branch
                    ? ((bus.res_taken != bus.res_pred_taken) ||
                       (bus.res_taken && (bus.res_target != bus.res_pred_target)))
                    : bus.res_pred_taken;
  assign correctPc  = (bus.res_is_branch && bus.res_taken) ? bus.res_target
                                                           : bus.res_pc + ADDR_W'(4);
  assign flush      = bus.res_valid && mispredict;

  assign bus.imem_req          = (state == S_FETCH) && !stall && !flush;
  assign bus.imem_addr         = pc;
  assign bus.fetch_valid       = fetchValid;
  assign bus.fetch_pc          = fetchPc;
  assign bus.fetch_instr       = fetchInstr;
  assign bus.fetch_pred_taken  = fetchPredTaken;
  assign bus.fetch_pred_target = fetchPredTarget;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_FETCH;
      pc              <= RESET_PC;
      fetchValid      <= 1'b0;
      fetchPc         <= '0;
      fetchInstr      <= '0;
      fetchPredTaken  <= 1'b0;
      fetchPredTarget <= '0;
      halted          <= 1'b0;
      mispredictCnt   <= '0;
    end else begin
      state           <= stateNext;
      pc              <= pcNext;
      fetchValid      <= fetchValidNext;
      fetchPc         <= fetchPcNext;
      fetchInstr      <= fetchInstrNext;
      fetchPredTaken  <= fetchPredTakenNext;
      fetchPredTarget <= fetchPredTargetNext;
      halted          <= (stateNext == S_HALTED);
      mispredictCnt   <= cntNext;
    end
  end

  // Priority: flush > stall > fetch
  always_comb begin
    stateNext           = state;
    pcNext              = pc;
    fetchValidNext      = fetchValid;
    fetchPcNext         = fetchPc;
    fetchInstrNext      = fetchInstr;
    fetchPredTakenNext  = fetchPredTaken;
    fetchPredTargetNext = fetchPredTarget;
    cntNext             = mispredictCnt;
    if (flush) begin
      pcNext         = correctPc;
      fetchValidNext = 1'b0;
      stateNext      = S_FETCH;
      if (!(&mispredictCnt)) cntNext = mispredictCnt + CNT_W'(1);
    end else if (!stall) begin
      if (state == S_FETCH && bus.imem_ready) begin
        fetchValidNext      = 1'b1;
        fetchPcNext         = pc;
        fetchInstrNext      = bus.imem_rdata;
        fetchPredTakenNext  = predTaken;
        fetchPredTargetNext = nextPc;
        pcNext              = nextPc;
        if (bus.imem_rdata[31:26] == HALT_OP) stateNext = S_HALTED;
      end else begin
        fetchValidNext = 1'b0;
      end
    end
  end

  // Predictor training from resolved branches, independent of stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        bht[i]       <= 2'b01;
        btbValid[i]  <= 1'b0;
        btbTag[i]    <= '0;
        btbTarget[i] <= '0;
      end
    end else if (bus.res_valid && bus.res_is_branch) begin
      if (bus.res_taken) begin
        if (bht[resIdx] != 2'b11) bht[resIdx] <= bht[resIdx] + 2'b01;
        btbValid[resIdx]  <= 1'b1;
        btbTag[resIdx]    <= resTag;
        btbTarget[resIdx] <= bus.res_target;
      end else if (bht[resIdx] != 2'b00) begin
        bht[resIdx] <= bht[resIdx] - 2'b01;
      end
    end
  end
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed table-driven bench for mips_fetch_unit: sequential fetch, bubbles, stall,
// predictor training, mispredict redirect, halt, and asynchronous mid-run reset.
module tb_mips_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        halted;
  logic [15:0] mispredictCnt;
  int          checks = 0;
  int          errors = 0;

  mips_fetch_unit_if #(.ADDR_W(32)) bus ();

  mips_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .bus           (bus),
    .flush         (flush),
    .halted        (halted),
    .mispredictCnt (mispredictCnt)
  );

  always #5 clk = ~clk;

  // Instruction memory: one halt word at 0x3004, otherwise an opcode-0x08 word tagged by address
  function automatic logic [31:0] instrFor(input logic [31:0] a);
    if (a == 32'h0000_3004) return 32'hFC00_0000;
    return {16'h2000, a[15:0]};
  endfunction

  always_comb bus.imem_rdata = instrFor(bus.imem_addr);

  typedef struct {
    logic        rdy, stl, rv, rb;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eFv;
    logic [31:0] eFpc;
    logic        ePt;
    logic [31:0] ePtgt;
    logic        eFl, eHlt;
    logic [15:0] eCnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rdy, stl, rv, rb, input logic [31:0] rpc, input logic rt,
    input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt,
    input logic eReq, input logic [31:0] eAddr, input logic eFv, input logic [31:0] eFpc,
    input logic ePt, input logic [31:0] ePtgt, input logic eFl, eHlt, input logic [15:0] eCnt);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rv = rv; v.rb = rb; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt;
    v.rpt = rpt; v.rptgt = rptgt; v.eReq = eReq; v.eAddr = eAddr; v.eFv = eFv;
    v.eFpc = eFpc; v.ePt = ePt; v.ePtgt = ePtgt; v.eFl = eFl; v.eHlt = eHlt; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic driveRes(input logic rv, rb, input logic [31:0] rpc, input logic rt,
                          input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt);
    bus.res_valid = rv; bus.res_is_branch = rb; bus.res_pc = rpc; bus.res_taken = rt;
    bus.res_target = rtgt; bus.res_pred_taken = rpt; bus.res_pred_target = rptgt;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    bus.imem_ready = 1'b0;
    driveRes(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);

    //          rdy stl rv rb rpc           rt rtgt          rpt rptgt         req addr          fv fpc           pt ptgt          fl h  cnt
    // sequential fetch, two-cycle imem bubble
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1000, 0, 32'h0,    0, 32'h0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1004, 1, 32'h1000, 0, 32'h1004, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1008, 1, 32'h1004, 0, 32'h1008, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1008, 0, 32'h0,    0, 32'h0,    0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1008, 0, 32'h0,    0, 32'h0,    0, 0, 0));
    // stall for 3 cycles with correctly predicted resolves
    vecs.push_back(mk(1, 1, 1, 0, 32'h0F00,   0, 32'h0,      0, 32'h0F04,   0, 32'h100C, 1, 32'h1008, 0, 32'h100C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0F04,   0, 32'h0,      0, 32'h0F08,   0, 32'h100C, 1, 32'h1008, 0, 32'h100C, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 32'h1040,   0, 32'h5000,   0, 32'h1044,   0, 32'h100C, 1, 32'h1008, 0, 32'h100C, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h100C, 1, 32'h1008, 0, 32'h100C, 0, 0, 0));
    // branch at 0x1010 trained taken to 0x2000
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1010, 1, 32'h100C, 0, 32'h1010, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h1010,   1, 32'h2000,   0, 32'h1014,   0, 32'h1014, 1, 32'h1010, 0, 32'h1014, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 32'h1010,   1, 32'h2000,   0, 32'h1014,   0, 32'h2000, 0, 32'h0,    0, 32'h0,    1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100C,   0, 32'h0,      1, 32'h2000,   0, 32'h2000, 0, 32'h0,    0, 32'h0,    1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1010, 0, 32'h0,    0, 32'h0,    0, 0, 3));
    vecs.push_back(mk(1, 0, 1, 1, 32'h1010,   1, 32'h2000,   1, 32'h2000,   1, 32'h2000, 1, 32'h1010, 1, 32'h2000, 0, 0, 3));
    // taken-predicted branch resolved not-taken twice
    vecs.push_back(mk(1, 0, 1, 1, 32'h1010,   0, 32'h2000,   1, 32'h2000,   0, 32'h2004, 1, 32'h2000, 0, 32'h2004, 1, 0, 3));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100C,   0, 32'h0,      1, 32'h2000,   0, 32'h1014, 0, 32'h0,    0, 32'h0,    1, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1010, 0, 32'h0,    0, 32'h0,    0, 0, 5));
    vecs.push_back(mk(1, 0, 1, 1, 32'h1010,   0, 32'h2000,   1, 32'h2000,   0, 32'h2000, 1, 32'h1010, 1, 32'h2000, 1, 0, 5));
    vecs.push_back(mk(1, 0, 1, 0, 32'h100C,   0, 32'h0,      1, 32'h2000,   0, 32'h1014, 0, 32'h0,    0, 32'h0,    1, 0, 6));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1010, 0, 32'h0,    0, 32'h0,    0, 0, 7));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h1014, 1, 32'h1010, 0, 32'h1014, 0, 0, 7));
    // flush beats stall, redirect to 0x3000
    vecs.push_back(mk(1, 1, 1, 0, 32'h2FFC,   0, 32'h0,      1, 32'h4000,   0, 32'h1018, 1, 32'h1014, 0, 32'h1018, 1, 0, 7));
    // halt at 0x3004, then flush restarts fetch
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h3000, 0, 32'h0,    0, 32'h0,    0, 0, 8));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h3004, 1, 32'h3000, 0, 32'h3004, 0, 0, 8));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h3008, 1, 32'h3004, 0, 32'h3008, 0, 1, 8));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      0, 32'h3008, 0, 32'h0,    0, 32'h0,    0, 1, 8));
    vecs.push_back(mk(1, 0, 1, 0, 32'h2FFC,   0, 32'h0,      1, 32'h4000,   0, 32'h3008, 0, 32'h0,    0, 32'h0,    1, 1, 8));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h3000, 0, 32'h0,    0, 32'h0,    0, 0, 9));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 32'h0,      1, 32'h3004, 1, 32'h3000, 0, 32'h3004, 0, 0, 9));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst imem_addr", bus.imem_addr, 32'h1000);
    chk("rst fetch_valid", 32'(bus.fetch_valid), 32'h0);
    chk("rst fetch_pc", bus.fetch_pc, 32'h0);
    chk("rst fetch_instr", bus.fetch_instr, 32'h0);
    chk("rst fetch_pred_target", bus.fetch_pred_target, 32'h0);
    chk("rst halted", 32'(halted), 32'h0);
    chk("rst mispredict_cnt", 32'(mispredictCnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.imem_ready = vecs[i].rdy;
      stall = vecs[i].stl;
      driveRes(vecs[i].rv, vecs[i].rb, vecs[i].rpc, vecs[i].rt, vecs[i].rtgt,
               vecs[i].rpt, vecs[i].rptgt);
      #1;
      chk($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(vecs[i].eReq));
      chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].eAddr);
      chk($sformatf("v%0d fetch_valid", i), 32'(bus.fetch_valid), 32'(vecs[i].eFv));
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].eFl));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'(vecs[i].eHlt));
      chk($sformatf("v%0d mispredict_cnt", i), 32'(mispredictCnt), 32'(vecs[i].eCnt));
      if (vecs[i].eFv) begin
        chk($sformatf("v%0d fetch_pc", i), bus.fetch_pc, vecs[i].eFpc);
        chk($sformatf("v%0d fetch_instr", i), bus.fetch_instr, instrFor(vecs[i].eFpc));
        chk($sformatf("v%0d fetch_pred_taken", i), 32'(bus.fetch_pred_taken), 32'(vecs[i].ePt));
        chk($sformatf("v%0d fetch_pred_target", i), bus.fetch_pred_target, vecs[i].ePtgt);
      end
    end

    // asynchronous reset mid-run takes effect without a clock edge
    @(negedge clk);
    driveRes(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
    stall = 1'b0;
    #1;
    chk("pre-rst halted", 32'(halted), 32'h1);
    rst = 1'b1;
    #1;
    chk("async rst imem_addr", bus.imem_addr, 32'h1000);
    chk("async rst fetch_valid", 32'(bus.fetch_valid), 32'h0);
    chk("async rst halted", 32'(halted), 32'h0);
    chk("async rst mispredict_cnt", 32'(mispredictCnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post-rst imem_addr", bus.imem_addr, 32'h1004);
    chk("post-rst fetch_valid", 32'(bus.fetch_valid), 32'h1);
    chk("post-rst fetch_pc", bus.fetch_pc, 32'h1000);
    chk("post-rst fetch_pred_taken", 32'(bus.fetch_pred_taken), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
